sme_match_collector: RTL
========================

SME_MATCH_COLLECTOR -- requirements
Module: sme_match_collector

Interface
REQ-001 The block SHALL use one clock; reset is asynchronous and active-low.
REQ-002 Parameter: DEPTH, 16, number of result FIFO entries (power of two).
REQ-003 Parameter: CNT_W, 12, width of each per-pattern match counter.
REQ-004 clk  input  1  rising-edge clock shared with the matcher.
REQ-005 reset  input  1  asynchronous, active-low reset.
REQ-006 pattern_no  input  4  pattern index from the matcher, qualified by valid.
REQ-007 match_addr  input  12  text address of the match, qualified by valid.
REQ-008 valid  input  1  single-cycle match strobe from the matcher.
REQ-009 finish  input  1  single-cycle end-of-run strobe from the matcher.
REQ-010 out_valid  output  1  a FIFO head entry is presented.
REQ-011 out_ready  input  1  consumer accepts the head entry when it is high together with out_valid.
REQ-012 out_pattern_no  output  4  pattern index of the head entry.
REQ-013 out_match_addr  output  12  match address of the head entry.
REQ-014 cnt_sel  input  4  selects the per-pattern counter to read.
REQ-015 cnt_data  output  CNT_W  counter value for cnt_sel, combinational.
REQ-016 overflow  output  1  sticky flag: at least one match was dropped.
REQ-017 done  output  1  run finished and FIFO drained.

Function
REQ-018 States SHALL be IDLE, COLLECT, DRAIN and DONE.
REQ-019 IDLE→COLLECT on the first cycle after reset deasserts.
REQ-020 COLLECT→DRAIN on finish=1.
REQ-021 DRAIN→DONE when the FIFO is empty.
REQ-022 DONE is held until reset.
REQ-023 Captures: valid is captured only in COLLECT. valid in IDLE, DRAIN or DONE is ignored. valid coincident with finish in COLLECT is captured.
REQ-024 Duplicate suppression: a captured {pattern_no, match_addr} equal to the last accepted pair is discarded. Discarded pairs do not push, count or set overflow. The last-pair register is invalid after reset.
REQ-025 Accepted match: increments counter[pattern_no] by 1, saturating at 2^CNT_W-1 (no wrap).
REQ-026 Accepted match: pushes {pattern_no, match_addr} into the FIFO unless the FIFO is full with no pop in the same cycle.
REQ-027 Dropped push: the entry is discarded, overflow is set and stays set until reset, and the counter still increments.
REQ-028 Simultaneous push and pop when full SHALL succeed with occupancy unchanged.
REQ-029 Simultaneous push and pop when empty: the new entry appears at the head the next cycle.
REQ-030 The FIFO SHALL be first-word-fall-through.
REQ-031 An entry pushed in cycle N SHALL give out_valid=1 in cycle N+1 if the FIFO was empty; otherwise it appears in order.
REQ-032 Pop occurs on out_valid & out_ready.
REQ-033 While out_valid=1 and out_ready=0, out_pattern_no and out_match_addr SHALL hold stable.
REQ-034 Read and write pointers SHALL wrap modulo DEPTH. Full/empty are distinguished by an extra pointer bit or an occupancy count 0..DEPTH.
REQ-035 done SHALL be asserted in the cycle after entering DONE and remain 1. out_valid is 0 whenever done=1.
REQ-036 cnt_data SHALL equal counter[cnt_sel] in the same cycle, reflecting updates from the previous edge.

Reset
REQ-037 On reset=0, with no clock required: state=IDLE, FIFO empty, all counters 0, last-pair invalid.
REQ-038 On reset=0, outputs SHALL be: out_valid=0, out_pattern_no=0, out_match_addr=0, overflow=0, done=0.
REQ-039 Reset asserted mid-run SHALL discard all FIFO contents and counters immediately.
REQ-040 After reset deasserts, the block SHALL resume in IDLE.

Verification
REQ-041 Single match, out_ready=1: pattern_no=3, match_addr=0x05A, valid in COLLECT → out_valid=1 next cycle with 3/0x05A for one cycle; cnt_sel=3 gives cnt_data=1.
REQ-042 Duplicate: 3/0x05A strobed twice consecutively → one FIFO entry; counter[3]=1.
REQ-043 Overflow: out_ready=0, 17 distinct matches on pattern 1 → 16 entries retained in order; overflow=1; counter[1]=17. Then out_ready=1 → 16 pops, then out_valid=0.
REQ-044 Full with concurrent pop: FIFO full, out_ready=1, push 0x7FF → no drop; overflow stays 0; 0x7FF emerges last.
REQ-045 Finish and drain: 4 entries queued, finish pulse, out_ready=1 → valid strobes after finish are ignored; done=1 one cycle after the 4th pop.
REQ-046 Reset mid-drain: reset=0 with 5 entries queued → out_valid=0 and cnt_data=0 immediately; overflow=0 and done=0.

Source files
------------

// File: rtl/sme_match_collector.sv
// Collects matcher hits into a FWFT result FIFO with per-pattern saturating counters.
// Latency: an accepted match is visible at the FIFO head the cycle after capture.
// Backpressure: out_valid/out_ready handshake; a push into a full FIFO with no pop is dropped and flagged.
module sme_match_collector #(
  parameter int DEPTH = 16,
  parameter int CNT_W = 12
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [3:0]       pattern_no,
  input  logic [11:0]      match_addr,
  input  logic             valid,
  input  logic             finish,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [3:0]       out_pattern_no,
  output logic [11:0]      out_match_addr,
  input  logic [3:0]       cnt_sel,
  output logic [CNT_W-1:0] cnt_data,
  output logic             overflow,
  output logic             done
);

  localparam int AW = $clog2(DEPTH);

  typedef enum logic [1:0] {IDLE, COLLECT, DRAIN, DONE} state_t;

  state_t            state;
  state_t            state_nxt;
  logic [15:0]       mem [DEPTH];
  logic [AW:0]       wr_ptr;
  logic [AW:0]       rd_ptr;
  logic [CNT_W-1:0]  cnt [16];
  logic              last_vld;
  logic [15:0]       last_pair;
  logic [15:0]       in_pair;
  logic [15:0]       head;
  logic              empty;
  logic              full;
  logic              pop;
  logic              capture;
  logic              dup;
  logic              accept;
  logic              push;
  logic              drop;

  // Extra pointer bit tells a full FIFO apart from an empty one.
  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign in_pair = {pattern_no, match_addr};
  assign capture = valid && (state == COLLECT);
  assign dup     = last_vld && (in_pair == last_pair);
  assign accept  = capture && !dup;
  // A full FIFO still takes a push when the head leaves in the same cycle.
  assign push    = accept && (!full || pop);
  assign drop    = accept && full && !pop;

  assign out_valid      = !empty && (state != DONE);
  assign pop            = out_valid && out_ready;
  assign head           = mem[rd_ptr[AW-1:0]];
  // Head fields read as zero when nothing is presented (memory is not reset).
  assign out_pattern_no = out_valid ? head[15:12] : 4'd0;
  assign out_match_addr = out_valid ? head[11:0]  : 12'd0;
  assign cnt_data       = cnt[cnt_sel];
  assign done           = (state == DONE);

  // State register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_nxt;
  end

  // Run sequencing: idle one cycle, collect until finish, drain, then hold.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    state_nxt = COLLECT;
      COLLECT: if (finish) state_nxt = DRAIN;
      DRAIN:   if (empty)  state_nxt = DONE;
      DONE:    state_nxt = DONE;
      default: state_nxt = IDLE;
    endcase
  end

  // FIFO storage; contents are don't-care until written.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr[AW-1:0]] <= in_pair;
  end

  // FIFO pointers, wrapping naturally modulo 2*DEPTH.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  // Last accepted pair for back-to-back duplicate suppression.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      last_vld  <= 1'b0;
      last_pair <= '0;
    end else if (accept) begin
      last_vld  <= 1'b1;
      last_pair <= in_pair;
    end
  end

  // Sticky drop flag.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)    overflow <= 1'b0;
    else if (drop) overflow <= 1'b1;
  end

  // Per-pattern match counters, saturating; dropped entries still count.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < 16; i++) cnt[i] <= '0;
    end else if (accept && (cnt[pattern_no] != {CNT_W{1'b1}})) begin
      cnt[pattern_no] <= cnt[pattern_no] + CNT_W'(1);
    end
  end

endmodule
